// File: rtl/amo_unit.sv
// RV32A word atomics (LR/SC/AMO*) executed as a read-modify-write sequence; holds the LR/SC reservation.
// Latency to amo_done: AMO 4, LR 3, SC pass 2, SC fail 1, misaligned 1 cycle(s) after amo_start.
// No backpressure on memory; amo_busy stalls the pipe and amo_start is ignored while busy.
package amo_pkg;
    typedef enum logic [3:0] {
        AMO_LR   = 4'd0,
        AMO_SC   = 4'd1,
        AMO_SWAP = 4'd2,
        AMO_ADD  = 4'd3,
        AMO_XOR  = 4'd4,
        AMO_AND  = 4'd5,
        AMO_OR   = 4'd6,
        AMO_MIN  = 4'd7,
        AMO_MAX  = 4'd8,
        AMO_MINU = 4'd9,
        AMO_MAXU = 4'd10
    } amoop_t;
endpackage

module amo_unit
    import amo_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            amo_start,
    input  amoop_t          amoop,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            st_snoop_en,
    input  logic [XLEN-1:0] st_snoop_addr,
    output logic            dm_rd_en,
    output logic            dm_wr_en,
    output logic [XLEN-1:0] dm_addr,
    output logic [XLEN-1:0] dm_wdata,
    input  logic [XLEN-1:0] dm_rdata,
    output logic            amo_busy,
    output logic            amo_done,
    output logic            amo_misaligned,
    output logic [XLEN-1:0] rd_data
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_RWAIT = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] addr_q;
    amoop_t          op_q;
    logic [XLEN-1:0] rs2_q;
    logic [XLEN-1:0] mem_q;
    logic [XLEN-1:0] rd_q;
    logic            mis_q;
    logic            res_vld;
    logic [XLEN-3:0] res_addr;

    logic            rd_ld;
    logic [XLEN-1:0] rd_nxt;
    logic [XLEN-1:0] result;
    logic            start_ok;
    logic            start_mis;
    logic            sc_ok;

    assign start_ok  = (state == S_IDLE) && amo_start;
    assign start_mis = (addr[1:0] != 2'b00);
    assign sc_ok     = res_vld && (res_addr == addr[XLEN-1:2]);

    // Next state plus the rd value, loaded exactly when entering DONE so rd_data changes with amo_done.
    always_comb begin
        state_nxt = state;
        rd_ld     = 1'b0;
        rd_nxt    = '0;
        case (state)
            S_IDLE: begin
                if (amo_start) begin
                    if (start_mis) begin
                        state_nxt = S_DONE;
                        rd_ld     = 1'b1;
                    end else if (amoop == AMO_SC) begin
                        if (sc_ok) begin
                            state_nxt = S_WRITE;
                        end else begin
                            state_nxt = S_DONE;
                            rd_ld     = 1'b1;
                            rd_nxt    = {{(XLEN-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        state_nxt = S_READ;
                    end
                end
            end
            S_READ:  state_nxt = S_RWAIT;
            S_RWAIT: begin
                if (op_q == AMO_LR) begin
                    state_nxt = S_DONE;
                    rd_ld     = 1'b1;
                    rd_nxt    = dm_rdata;
                end else begin
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                state_nxt = S_DONE;
                rd_ld     = 1'b1;
                rd_nxt    = (op_q == AMO_SC) ? '0 : mem_q;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Write data; SWAP, SC and any undefined encoding store rs2 unchanged. Ties in MIN/MAX keep mem_q.
    always_comb begin
        case (op_q)
            AMO_ADD:  result = mem_q + rs2_q;
            AMO_XOR:  result = mem_q ^ rs2_q;
            AMO_AND:  result = mem_q & rs2_q;
            AMO_OR:   result = mem_q | rs2_q;
            AMO_MIN:  result = ($signed(rs2_q) < $signed(mem_q)) ? rs2_q : mem_q;
            AMO_MAX:  result = ($signed(rs2_q) > $signed(mem_q)) ? rs2_q : mem_q;
            AMO_MINU: result = (rs2_q < mem_q) ? rs2_q : mem_q;
            AMO_MAXU: result = (rs2_q > mem_q) ? rs2_q : mem_q;
            default:  result = rs2_q;
        endcase
    end

    // State register and operand capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            addr_q <= '0;
            op_q   <= AMO_LR;
            rs2_q  <= '0;
            mem_q  <= '0;
            rd_q   <= '0;
            mis_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (rd_ld) begin
                rd_q <= rd_nxt;
            end
            if (start_ok) begin
                addr_q <= addr;
                op_q   <= amoop;
                rs2_q  <= rs2_data;
                mis_q  <= start_mis;
            end
            if (state == S_RWAIT) begin
                mem_q <= dm_rdata;
            end
        end
    end

    // Reservation: LR sets (beating a same-cycle snoop), any aligned SC or matching store clears.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_vld  <= 1'b0;
            res_addr <= '0;
        end else if ((state == S_RWAIT) && (op_q == AMO_LR)) begin
            res_vld  <= 1'b1;
            res_addr <= addr_q[XLEN-1:2];
        end else if (start_ok && !start_mis && (amoop == AMO_SC)) begin
            res_vld <= 1'b0;
        end else if (st_snoop_en && (st_snoop_addr[XLEN-1:2] == res_addr)) begin
            res_vld <= 1'b0;
        end
    end

    // Strobes are masked by rst so an aborted operation never touches memory.
    assign dm_rd_en       = (state == S_READ) && !rst;
    assign dm_wr_en       = (state == S_WRITE) && !rst;
    assign dm_addr        = {addr_q[XLEN-1:2], 2'b00};
    assign dm_wdata       = (state == S_WRITE) ? result : '0;
    assign amo_busy       = (state != S_IDLE);
    assign amo_done       = (state == S_DONE);
    assign amo_misaligned = (state == S_DONE) && mis_q;
    assign rd_data        = rd_q;

endmodule

// File: tb/tb_amo_unit.sv
// Directed bench for amo_unit with a behavioural word memory and a done-triggered scoreboard.
// Each issued operation queues its expected rd, flags, latency and memory traffic.
// The monitor pops one entry per amo_done and compares it against what it observed.
module tb_amo_unit;
    import amo_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        amo_start = 1'b0;
    amoop_t      amoop = AMO_LR;
    logic [31:0] addr = '0;
    logic [31:0] rs2_data = '0;
    logic        st_snoop_en = 1'b0;
    logic [31:0] st_snoop_addr = '0;
    logic        dm_rd_en;
    logic        dm_wr_en;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata = '0;
    logic        amo_busy;
    logic        amo_done;
    logic        amo_misaligned;
    logic [31:0] rd_data;

    amo_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .amo_start(amo_start), .amoop(amoop), .addr(addr),
        .rs2_data(rs2_data), .st_snoop_en(st_snoop_en), .st_snoop_addr(st_snoop_addr),
        .dm_rd_en(dm_rd_en), .dm_wr_en(dm_wr_en), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .amo_busy(amo_busy), .amo_done(amo_done),
        .amo_misaligned(amo_misaligned), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] rd;
        logic        mis;
        int          lat;
        int          n_rd;
        int          n_wr;
        logic [31:0] wdat;
        int          start;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          passes = 0;
    int          cyc = 0;
    int          op_id = 0;
    int          overlap = 0;
    logic        mem_load = 1'b0;
    logic [31:0] mem [256];

    // Word memory: read data appears the cycle after dm_rd_en.
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[8'h40] <= 32'd5;
            mem[8'h44] <= 32'hFFFF_FFFF;
            mem[8'h48] <= 32'hFFFF_FFFF;
            mem[8'h4C] <= 32'hFFFF_FFFF;
            mem[8'h50] <= 32'hF0F0_F0F0;
            mem[8'h54] <= 32'd7;
            mem[8'h58] <= 32'h0000_003C;
            mem[8'h80] <= 32'h0000_0055;
        end else begin
            if (dm_wr_en) mem[dm_addr[9:2]] <= dm_wdata;
            if (dm_rd_en) dm_rdata <= mem[dm_addr[9:2]];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Monitor: tally memory traffic per operation, score it on amo_done.
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [31:0] wr_seen = '0;
    exp_t        e_mon;
    always @(negedge clk) begin
        if (rst) begin
            rd_cnt = 0;
            wr_cnt = 0;
        end else begin
            if (dm_rd_en && dm_wr_en) overlap++;
            if (dm_rd_en) rd_cnt++;
            if (dm_wr_en) begin
                wr_cnt++;
                wr_seen = dm_wdata;
            end
            if (amo_done) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
                end else begin
                    e_mon = sb.pop_front();
                    chk($sformatf("op%0d rd_data", e_mon.id), rd_data, e_mon.rd);
                    chk($sformatf("op%0d misaligned", e_mon.id), {31'b0, amo_misaligned}, {31'b0, e_mon.mis});
                    chk($sformatf("op%0d latency", e_mon.id), cyc - e_mon.start, e_mon.lat);
                    chk($sformatf("op%0d rd_strobes", e_mon.id), rd_cnt, e_mon.n_rd);
                    chk($sformatf("op%0d wr_strobes", e_mon.id), wr_cnt, e_mon.n_wr);
                    if (e_mon.n_wr > 0 && wr_cnt > 0)
                        chk($sformatf("op%0d wdata", e_mon.id), wr_seen, e_mon.wdat);
                end
                rd_cnt = 0;
                wr_cnt = 0;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (amo_busy && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (amo_busy) begin
            checks++;
            $display("FAIL idle_timeout: got busy after %0d cycles expected idle", n);
        end
    endtask

    task automatic op(input amoop_t o, input logic [31:0] a, input logic [31:0] r,
                      input logic [31:0] erd, input logic emis, input int elat,
                      input int enr, input int enw, input logic [31:0] ewd, input int hold);
        exp_t e;
        wait_idle();
        e.id = op_id; e.rd = erd; e.mis = emis; e.lat = elat;
        e.n_rd = enr; e.n_wr = enw; e.wdat = ewd; e.start = cyc;
        op_id++;
        sb.push_back(e);
        amo_start = 1'b1; amoop = o; addr = a; rs2_data = r;
        repeat (hold) @(posedge clk);
        #1;
        amo_start = 1'b0;
    endtask

    task automatic snoop(input logic [31:0] a);
        wait_idle();
        st_snoop_en = 1'b1; st_snoop_addr = a;
        @(posedge clk); #1;
        st_snoop_en = 1'b0;
    endtask

    initial begin
        int n;
        mem_load = 1'b1;
        @(posedge clk); #1;
        mem_load = 1'b0;
        @(posedge clk); #1;
        chk("reset busy", {31'b0, amo_busy}, 32'd0);
        chk("reset done", {31'b0, amo_done}, 32'd0);
        chk("reset rd_en", {31'b0, dm_rd_en}, 32'd0);
        chk("reset wr_en", {31'b0, dm_wr_en}, 32'd0);
        chk("reset rd_data", rd_data, 32'd0);
        chk("reset dm_addr", dm_addr, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        //  op         addr          rs2           rd            mis  lat rd wr wdata        hold
        op(AMO_ADD,  32'h100, 32'd7,         32'd5,         1'b0, 4, 1, 1, 32'd12,        1);
        op(AMO_MIN,  32'h110, 32'd1,         32'hFFFF_FFFF, 1'b0, 4, 1, 1, 32'hFFFF_FFFF, 1);
        op(AMO_MINU, 32'h120, 32'd1,         32'hFFFF_FFFF, 1'b0, 4, 1, 1, 32'd1,         1);
        op(AMO_LR,   32'h200, 32'd0,         32'h55,        1'b0, 3, 1, 0, 32'd0,         1);
        op(AMO_SC,   32'h200, 32'd9,         32'd0,         1'b0, 2, 0, 1, 32'd9,         1);
        wait_idle();
        chk("mem after SC", mem[8'h80], 32'd9);
        op(AMO_SC,   32'h200, 32'd3,         32'd1,         1'b0, 1, 0, 0, 32'd0,         1);
        op(AMO_LR,   32'h200, 32'd0,         32'd9,         1'b0, 3, 1, 0, 32'd0,         1);
        snoop(32'h202);
        op(AMO_SC,   32'h200, 32'd4,         32'd1,         1'b0, 1, 0, 0, 32'd0,         1);
        op(AMO_LR,   32'h200, 32'd0,         32'd9,         1'b0, 3, 1, 0, 32'd0,         1);
        snoop(32'h204);
        op(AMO_SC,   32'h200, 32'd4,         32'd0,         1'b0, 2, 0, 1, 32'd4,         1);
        op(AMO_OR,   32'h103, 32'hFF,        32'd0,         1'b1, 1, 0, 0, 32'd0,         1);
        op(AMO_ADD,  32'h130, 32'd2,         32'hFFFF_FFFF, 1'b0, 4, 1, 1, 32'd1,         1);
        op(AMO_MAX,  32'h110, 32'd1,         32'hFFFF_FFFF, 1'b0, 4, 1, 1, 32'd1,         1);
        op(AMO_MAXU, 32'h120, 32'h8000_0000, 32'd1,         1'b0, 4, 1, 1, 32'h8000_0000, 1);
        op(AMO_XOR,  32'h140, 32'hFF00_FF00, 32'hF0F0_F0F0, 1'b0, 4, 1, 1, 32'h0FF0_0FF0, 1);
        op(AMO_AND,  32'h140, 32'h00FF_FF00, 32'h0FF0_0FF0, 1'b0, 4, 1, 1, 32'h00F0_0F00, 1);
        op(AMO_MIN,  32'h150, 32'd7,         32'd7,         1'b0, 4, 1, 1, 32'd7,         1);
        op(amoop_t'(4'hF), 32'h150, 32'hABCD, 32'd7,        1'b0, 4, 1, 1, 32'hABCD,      1);
        op(AMO_ADD,  32'h100, 32'd1,         32'd12,        1'b0, 4, 1, 1, 32'd13,        5);
        op(AMO_LR,   32'h200, 32'd0,         32'd4,         1'b0, 3, 1, 0, 32'd0,         1);

        // AMOSWAP aborted by reset while in WRITE; not scoreboarded.
        wait_idle();
        amo_start = 1'b1; amoop = AMO_SWAP; addr = 32'h160; rs2_data = 32'hDEAD;
        @(posedge clk); #1;
        amo_start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort busy in write", {31'b0, amo_busy}, 32'd1);
        chk("abort wr_en", {31'b0, dm_wr_en}, 32'd0);
        @(posedge clk); #1;
        chk("abort busy after", {31'b0, amo_busy}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort mem", mem[8'h58], 32'h0000_003C);
        op(AMO_SC,   32'h200, 32'd5,         32'd1,         1'b0, 1, 0, 0, 32'd0,         1);

        n = 0;
        while ((sb.size() != 0 || amo_busy) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        chk("scoreboard drained", sb.size(), 32'd0);
        chk("rd/wr overlap", overlap, 32'd0);
        chk("final mem 0x100", mem[8'h40], 32'd13);
        chk("final mem 0x200", mem[8'h80], 32'd4);
        chk("final mem 0x150", mem[8'h54], 32'hABCD);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
